i2c_slave: RTL and testbench
============================

I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h55: 7-bit address this slave answers to.
REQ-002 SHALL have port clk, input, 1: system clock, all logic on rising edge, at least 8x SCL rate.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port scl, input, 1: I2C clock from the master; the slave never drives it.
REQ-005 SHALL have port sda, inout, 1: open-drain data; the slave drives only 1'b0 or 1'bz.
REQ-006 SHALL have port data_tx, input, 8: byte returned to the master in read mode; sampled when tx_req pulses.
REQ-007 SHALL have port data_rx, output, 8: last byte written by the master.
REQ-008 SHALL have port rx_valid, output, 1: one-clk pulse when data_rx updates.
REQ-009 SHALL have port tx_req, output, 1: one-clk pulse when data_tx is loaded into the shift register.
REQ-010 SHALL have port busy, output, 1: high from an address match until STOP or NACK release.
REQ-011 SHALL have port nack_rcvd, output, 1: one-clk pulse when the master NACKs a read byte.

Function
REQ-012 SHALL pass scl/sda through 2-FF synchronizers; all edge detection SHALL use the synchronized values.
REQ-013 SHALL detect START on sda falling while scl is high, and STOP on sda rising while scl is high.
REQ-014 SHALL implement states IDLE, ADDR, ACK_ADDR, WRITE, ACK_WRITE, READ, ACK_READ.
REQ-015 SHALL move from any state to ADDR on START, including a repeated START mid-transfer.
REQ-016 SHALL move from any state to IDLE on STOP.
REQ-017 SHALL, in ADDR, WRITE and ACK_READ, sample sda on scl rising edge, MSB first; a bit counter counts 0..7.
REQ-018 SHALL, after 8 address bits, on a match with SLAVE_ADDR: go to ACK_ADDR, drive sda=0 from the next scl falling edge to the following scl falling edge, and set busy.
REQ-019 SHALL, after 8 address bits, on a mismatch: return to IDLE with sda=z and no other output change.
REQ-020 SHALL, on leaving ACK_ADDR, go to WRITE if R/W bit=0; if R/W bit=1, go to READ, load data_tx, and pulse tx_req.
REQ-021 SHALL, after the 8th WRITE bit, update data_rx, pulse rx_valid, go to ACK_WRITE to drive ACK, then return to WRITE.
REQ-022 SHALL, in READ, present each bit on sda (0 -> drive low, 1 -> z) at scl falling edge, MSB first.
REQ-023 SHALL, after the 8th READ bit, release sda and enter ACK_READ.
REQ-024 SHALL, in ACK_READ, sample sda at scl rising edge: on ACK (0), reload data_tx, pulse tx_req and return to READ; on NACK (1), pulse nack_rcvd, release sda, clear busy and go to IDLE.
REQ-025 SHALL ignore SCL edges in IDLE.
REQ-026 SHALL never change the sda drive while synchronized scl is high, except on reset.

Reset
REQ-027 SHALL, on reset low, immediately set: state IDLE, sda=z, data_rx=8'h00, rx_valid=0, tx_req=0, busy=0, nack_rcvd=0, counter=0, synchronizers=1.
REQ-028 SHALL, after a reset asserted mid-transfer, wait for a fresh START before responding.

Configuration
REQ-029 SHALL use macro I2C_SLAVE_GLITCH_FILTER_EN: when defined, a 3-sample majority filter follows each synchronizer, adding 2 clk latency; when undefined, synchronizer outputs are used directly.

Structure
REQ-030 SHALL take state encodings and the I2C_ACK/I2C_NACK constants from shared package i2c_pkg, also used by i2c_master.
REQ-031 SHALL implement synchronizer, optional filter and rise/fall edge detection in sub-module i2c_sync_edge, instantiated once for scl and once for sda.

Verification
REQ-032 SHALL verify: master writes addr 0x55, W, data 0xA5 -> slave ACKs both bytes, data_rx=8'hA5, one rx_valid pulse, busy cleared on STOP.
REQ-033 SHALL verify: addr 0x2A -> sda stays z through the 9th clock (NACK), state IDLE, busy=0.
REQ-034 SHALL verify: addr 0x55, R, data_tx=8'hBC, master ACK, then NACK -> sda carries 1011_1100 twice, two tx_req pulses, one nack_rcvd pulse.
REQ-035 SHALL verify: repeated START after the write address byte, then read -> slave re-decodes the address and enters READ without a STOP.
REQ-036 SHALL verify: reset asserted at write bit 4 -> sda=z immediately, data_rx=0, no ACK until the next START.
REQ-037 SHALL verify: a 1-clk low glitch on scl with I2C_SLAVE_GLITCH_FILTER_EN defined -> no bit shifted; without the macro -> documented spurious sample.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, ACK/NACK bus levels and a
// 3-input majority helper used by the optional glitch filter.
package i2c_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ACK_ADDR,
      WRITE,
      ACK_WRITE,
      READ,
      ACK_READ
   } i2cState_t;

   localparam logic I2C_ACK  = 1'b0;
   localparam logic I2C_NACK = 1'b1;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// 2-FF synchronizer with rise/fall detection for one I2C line.
// Define I2C_SLAVE_GLITCH_FILTER_EN to add a 3-sample majority filter (+2 clk latency).
module i2c_sync_edge
   import i2c_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic i_in,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic [1:0] r_sync;
   logic       r_prev;
   logic       w_level;

   // Lines idle high, so the synchronizer resets to 1 to avoid a fake edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync <= 2'b11;
      end else begin
         r_sync <= {r_sync[0], i_in};
      end
   end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
   logic [1:0] r_hist;
   logic       r_filt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hist <= 2'b11;
         r_filt <= 1'b1;
      end else begin
         r_hist <= {r_hist[0], r_sync[1]};
         r_filt <= majority3(r_sync[1], r_hist[0], r_hist[1]);
      end
   end

   assign w_level = r_filt;
`else
   assign w_level = r_sync[1];
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_prev <= 1'b1;
      end else begin
         r_prev <= w_level;
      end
   end

   assign o_level = w_level;
   assign o_rise  = w_level & ~r_prev;
   assign o_fall  = ~w_level & r_prev;

endmodule

// File: rtl/i2c_slave.sv
// I2C slave with 7-bit address, byte write and read, ACK/NACK handling.
// Optional SCL/SDA glitch filter enabled by defining I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_slave
   import i2c_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR = 7'h55
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic       scl,
   inout  wire        sda,
   input  logic [7:0] data_tx,
   output logic [7:0] data_rx,
   output logic       rx_valid,
   output logic       tx_req,
   output logic       busy,
   output logic       nack_rcvd
);

   i2cState_t  r_state;
   logic [2:0] r_bitCnt;
   logic [7:0] r_shift;
   logic [7:0] r_dataRx;
   logic       r_sdaOe;
   logic       r_ackPhase;
   logic       r_firstBit;
   logic       r_rw;
   logic       r_rxValid;
   logic       r_txReq;
   logic       r_busy;
   logic       r_nackRcvd;

   logic w_sclLevel, w_sclRise, w_sclFall;
   logic w_sdaLevel, w_sdaRise, w_sdaFall;
   logic w_start, w_stop;

   i2c_sync_edge u_sclSync (
      .clk     (clk),
      .reset   (reset),
      .i_in    (scl),
      .o_level (w_sclLevel),
      .o_rise  (w_sclRise),
      .o_fall  (w_sclFall)
   );

   i2c_sync_edge u_sdaSync (
      .clk     (clk),
      .reset   (reset),
      .i_in    (sda),
      .o_level (w_sdaLevel),
      .o_rise  (w_sdaRise),
      .o_fall  (w_sdaFall)
   );

   assign w_start = w_sdaFall & w_sclLevel;
   assign w_stop  = w_sdaRise & w_sclLevel;

   // All sda drive changes happen on a synchronized scl falling edge, never while scl is high.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_bitCnt   <= 3'd0;
         r_shift    <= 8'h00;
         r_dataRx   <= 8'h00;
         r_sdaOe    <= 1'b0;
         r_ackPhase <= 1'b0;
         r_firstBit <= 1'b0;
         r_rw       <= 1'b0;
         r_rxValid  <= 1'b0;
         r_txReq    <= 1'b0;
         r_busy     <= 1'b0;
         r_nackRcvd <= 1'b0;
      end else begin
         r_rxValid  <= 1'b0;
         r_txReq    <= 1'b0;
         r_nackRcvd <= 1'b0;
         if (w_start) begin
            r_state    <= ADDR;
            r_bitCnt   <= 3'd0;
            r_sdaOe    <= 1'b0;
            r_ackPhase <= 1'b0;
         end else if (w_stop) begin
            r_state  <= IDLE;
            r_bitCnt <= 3'd0;
            r_sdaOe  <= 1'b0;
            r_busy   <= 1'b0;
         end else begin
            case (r_state)
               IDLE: begin
               end
               ADDR: begin
                  if (w_sclRise) begin
                     r_shift <= {r_shift[6:0], w_sdaLevel};
                     if (r_bitCnt == 3'd7) begin
                        r_bitCnt <= 3'd0;
                        if (r_shift[6:0] == SLAVE_ADDR) begin
                           r_rw       <= w_sdaLevel;
                           r_busy     <= 1'b1;
                           r_ackPhase <= 1'b0;
                           r_state    <= ACK_ADDR;
                        end else begin
                           r_state <= IDLE;
                        end
                     end else begin
                        r_bitCnt <= r_bitCnt + 3'd1;
                     end
                  end
               end
               ACK_ADDR: begin
                  if (w_sclFall) begin
                     if (!r_ackPhase) begin
                        r_sdaOe    <= 1'b1;
                        r_ackPhase <= 1'b1;
                     end else begin
                        r_ackPhase <= 1'b0;
                        r_bitCnt   <= 3'd0;
                        // The falling edge that ends the ACK also presents the first read bit.
                        if (r_rw) begin
                           r_state    <= READ;
                           r_shift    <= data_tx;
                           r_txReq    <= 1'b1;
                           r_firstBit <= 1'b0;
                           r_sdaOe    <= ~data_tx[7];
                        end else begin
                           r_state <= WRITE;
                           r_sdaOe <= 1'b0;
                        end
                     end
                  end
               end
               WRITE: begin
                  if (w_sclRise) begin
                     r_shift <= {r_shift[6:0], w_sdaLevel};
                     if (r_bitCnt == 3'd7) begin
                        r_bitCnt   <= 3'd0;
                        r_dataRx   <= {r_shift[6:0], w_sdaLevel};
                        r_rxValid  <= 1'b1;
                        r_ackPhase <= 1'b0;
                        r_state    <= ACK_WRITE;
                     end else begin
                        r_bitCnt <= r_bitCnt + 3'd1;
                     end
                  end
               end
               ACK_WRITE: begin
                  if (w_sclFall) begin
                     if (!r_ackPhase) begin
                        r_sdaOe    <= 1'b1;
                        r_ackPhase <= 1'b1;
                     end else begin
                        r_sdaOe    <= 1'b0;
                        r_ackPhase <= 1'b0;
                        r_state    <= WRITE;
                     end
                  end
               end
               READ: begin
                  if (w_sclFall) begin
                     if (r_firstBit) begin
                        r_sdaOe    <= ~r_shift[7];
                        r_firstBit <= 1'b0;
                     end else if (r_bitCnt == 3'd7) begin
                        r_sdaOe  <= 1'b0;
                        r_bitCnt <= 3'd0;
                        r_state  <= ACK_READ;
                     end else begin
                        r_sdaOe  <= ~r_shift[6];
                        r_shift  <= {r_shift[6:0], 1'b0};
                        r_bitCnt <= r_bitCnt + 3'd1;
                     end
                  end
               end
               ACK_READ: begin
                  if (w_sclRise) begin
                     if (w_sdaLevel == I2C_ACK) begin
                        r_shift    <= data_tx;
                        r_txReq    <= 1'b1;
                        r_firstBit <= 1'b1;
                        r_bitCnt   <= 3'd0;
                        r_state    <= READ;
                     end else if (w_sdaLevel == I2C_NACK) begin
                        r_nackRcvd <= 1'b1;
                        r_sdaOe    <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= IDLE;
                     end
                  end
               end
               default: begin
                  r_state <= IDLE;
                  r_sdaOe <= 1'b0;
               end
            endcase
         end
      end
   end

   assign sda       = r_sdaOe ? 1'b0 : 1'bz;
   assign data_rx   = r_dataRx;
   assign rx_valid  = r_rxValid;
   assign tx_req    = r_txReq;
   assign busy      = r_busy;
   assign nack_rcvd = r_nackRcvd;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed testbench for i2c_slave: a bit-banged I2C master drives write, read,
// address-NACK, repeated START, mid-transfer reset and SCL glitch scenarios.
module tb_i2c_slave;
   import i2c_pkg::*;

   localparam int TQ = 6;

   logic       clk     = 1'b0;
   logic       reset   = 1'b0;
   logic       scl     = 1'b1;
   logic       sdaLow  = 1'b0;
   logic [7:0] dataTx  = 8'hBC;
   logic [7:0] dataRx;
   logic       rxValid;
   logic       txReq;
   logic       busy;
   logic       nackRcvd;
   wire        sda;

   int testCount = 0;
   int failCount = 0;
   int rxCount   = 0;
   int txCount   = 0;
   int nackCount = 0;

   pullup (sda);
   assign sda = sdaLow ? 1'b0 : 1'bz;

   always #5 clk = ~clk;

   i2c_slave #(.SLAVE_ADDR(7'h55)) dut (
      .clk       (clk),
      .reset     (reset),
      .scl       (scl),
      .sda       (sda),
      .data_tx   (dataTx),
      .data_rx   (dataRx),
      .rx_valid  (rxValid),
      .tx_req    (txReq),
      .busy      (busy),
      .nack_rcvd (nackRcvd)
   );

   always @(posedge clk) begin
      if (rxValid)  rxCount   <= rxCount + 1;
      if (txReq)    txCount   <= txCount + 1;
      if (nackRcvd) nackCount <= nackCount + 1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic waitClocks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One SCL period starting and ending with scl low; bitVal=1 releases sda.
   task automatic applyStimulus(input logic bitVal, input logic glitch, output logic sampled);
      waitClocks(TQ);
      sdaLow = ~bitVal;
      waitClocks(TQ);
      scl = 1'b1;
      if (glitch) begin
         waitClocks(2);
         scl = 1'b0;
         waitClocks(1);
         scl = 1'b1;
         waitClocks(TQ - 3);
      end else begin
         waitClocks(TQ);
      end
      sampled = sda;
      waitClocks(TQ);
      scl = 1'b0;
   endtask

   task automatic startCond();
      sdaLow = 1'b0;
      waitClocks(TQ);
      scl = 1'b1;
      waitClocks(TQ);
      sdaLow = 1'b1;
      waitClocks(TQ);
      scl = 1'b0;
   endtask

   task automatic stopCond();
      waitClocks(TQ);
      sdaLow = 1'b1;
      waitClocks(TQ);
      scl = 1'b1;
      waitClocks(TQ);
      sdaLow = 1'b0;
      waitClocks(2 * TQ);
   endtask

   task automatic writeByte(input logic [7:0] value, output logic ackLevel);
      logic s;
      for (int i = 7; i >= 0; i--) applyStimulus(value[i], 1'b0, s);
      applyStimulus(1'b1, 1'b0, ackLevel);
   endtask

   task automatic readByte(input logic masterAck, output logic [7:0] value);
      logic s;
      value = 8'h00;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 1'b0, s);
         value = {value[6:0], s};
      end
      applyStimulus(~masterAck, 1'b0, s);
   endtask

   initial begin
      logic       ack;
      logic       s;
      logic [7:0] rd;
      logic [7:0] pattern;
      int         rx0, tx0, nk0;

      // Reset state
      waitClocks(3);
      #1;
      checkOutput("rstSdaZ",     32'(sda),      32'h1);
      checkOutput("rstDataRx",   32'(dataRx),   32'h00);
      checkOutput("rstBusy",     32'(busy),     32'h0);
      checkOutput("rstPulses",   32'({rxValid, txReq, nackRcvd}), 32'h0);
      checkOutput("rstState",    32'(dut.r_state), 32'(IDLE));
      waitClocks(2);
      reset = 1'b1;
      waitClocks(5);

      // Write 0xA5 to address 0x55
      rx0 = rxCount;
      startCond();
      writeByte(8'hAA, ack);
      checkOutput("wrAddrAck", 32'(ack), 32'h0);
      waitClocks(TQ);
      checkOutput("wrBusy",    32'(busy), 32'h1);
      writeByte(8'hA5, ack);
      checkOutput("wrDataAck", 32'(ack), 32'h0);
      checkOutput("wrDataRx",  32'(dataRx), 32'hA5);
      checkOutput("wrRxPulse", 32'(rxCount - rx0), 32'd1);
      stopCond();
      checkOutput("wrBusyStop", 32'(busy), 32'h0);

      // Foreign address 0x2A is not acknowledged
      startCond();
      writeByte(8'h54, ack);
      checkOutput("nakAddrSda", 32'(ack), 32'h1);
      waitClocks(TQ);
      checkOutput("nakState",   32'(dut.r_state), 32'(IDLE));
      checkOutput("nakBusy",    32'(busy), 32'h0);
      checkOutput("nakDataRx",  32'(dataRx), 32'hA5);
      stopCond();

      // Read 0xBC twice: master ACKs first byte, NACKs second
      tx0 = txCount; nk0 = nackCount;
      startCond();
      writeByte(8'hAB, ack);
      checkOutput("rdAddrAck", 32'(ack), 32'h0);
      readByte(1'b1, rd);
      checkOutput("rdByte1",   32'(rd), 32'hBC);
      readByte(1'b0, rd);
      checkOutput("rdByte2",   32'(rd), 32'hBC);
      waitClocks(TQ);
      checkOutput("rdTxReq",   32'(txCount - tx0), 32'd2);
      checkOutput("rdNack",    32'(nackCount - nk0), 32'd1);
      checkOutput("rdBusy",    32'(busy), 32'h0);
      stopCond();

      // Repeated START: write address, then read address without STOP
      tx0 = txCount;
      startCond();
      writeByte(8'hAA, ack);
      checkOutput("rsWrAck",  32'(ack), 32'h0);
      startCond();
      writeByte(8'hAB, ack);
      checkOutput("rsRdAck",  32'(ack), 32'h0);
      waitClocks(TQ);
      checkOutput("rsState",  32'(dut.r_state), 32'(READ));
      checkOutput("rsBusy",   32'(busy), 32'h1);
      readByte(1'b0, rd);
      checkOutput("rsByte",   32'(rd), 32'hBC);
      checkOutput("rsTxReq",  32'(txCount - tx0), 32'd1);
      stopCond();

      // Reset asserted after four data bits of a write
      rx0 = rxCount;
      pattern = 8'hA5;
      startCond();
      writeByte(8'hAA, ack);
      checkOutput("rrAddrAck", 32'(ack), 32'h0);
      for (int i = 7; i >= 4; i--) applyStimulus(pattern[i], 1'b0, s);
      sdaLow = 1'b0;
      waitClocks(2);
      reset = 1'b0;
      #1;
      checkOutput("rrSdaZ",    32'(sda), 32'h1);
      checkOutput("rrDataRx",  32'(dataRx), 32'h00);
      checkOutput("rrBusy",    32'(busy), 32'h0);
      waitClocks(3);
      reset = 1'b1;
      for (int i = 3; i >= 0; i--) applyStimulus(pattern[i], 1'b0, s);
      applyStimulus(1'b1, 1'b0, ack);
      checkOutput("rrNoAck",   32'(ack), 32'h1);
      checkOutput("rrNoRx",    32'(rxCount - rx0), 32'd0);
      stopCond();
      startCond();
      writeByte(8'hAA, ack);
      checkOutput("rrFreshAck", 32'(ack), 32'h0);
      stopCond();

      // One-clk low glitch on scl during the first data bit
      rx0 = rxCount;
      startCond();
      writeByte(8'hAA, ack);
      checkOutput("glAddrAck", 32'(ack), 32'h0);
      for (int i = 7; i >= 0; i--) applyStimulus(pattern[i], (i == 7), s);
      applyStimulus(1'b1, 1'b0, ack);
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
      checkOutput("glDataRx",  32'(dataRx), 32'hA5);
      checkOutput("glAck",     32'(ack), 32'h0);
`else
      // Unfiltered: the glitch re-samples bit 7, so the byte closes one bit early.
      checkOutput("glDataRx",  32'(dataRx), 32'hD2);
      checkOutput("glAck",     32'(ack), 32'h1);
`endif
      checkOutput("glRxPulse", 32'(rxCount - rx0), 32'd1);
      stopCond();

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
